// File: rtl/delay_commutator_mdc.sv
// delay_commutator_mdc: radix-2 MDC delay commutator (lower delay line, 2x2 switch, upper delay line)
module delay_commutator_mdc #(
    parameter int DATA_W = 12,
    parameter int DELAY  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] UI_real,
    input  logic [DATA_W-1:0] UI_imag,
    input  logic [DATA_W-1:0] LI_real,
    input  logic [DATA_W-1:0] LI_imag,
    output logic              out_valid,
    output logic              out_sop,
    output logic [DATA_W-1:0] UO_real,
    output logic [DATA_W-1:0] UO_imag,
    output logic [DATA_W-1:0] LO_real,
    output logic [DATA_W-1:0] LO_imag
);
    localparam int L = $clog2(DELAY);
    localparam int W = 2 * DATA_W;
    localparam logic [L:0] KD = (L+1)'(DELAY);
    logic [L:0]   k, kk;
    logic         primed, pe, sel;
    logic [W-1:0] ldl [DELAY];
    logic [W-1:0] udl [DELAY];
    logic [W-1:0] a, b, ld, x, y;
    always_comb begin
        a   = {UI_real, UI_imag};
        b   = {LI_real, LI_imag};
        kk  = in_sop ? '0 : k;
        pe  = !in_sop && primed;
        sel = kk[L];
        ld  = ldl[DELAY-1];
        x   = sel ? ld : a;
        y   = sel ? a : ld;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k         <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            UO_real   <= '0;
            UO_imag   <= '0;
            LO_real   <= '0;
            LO_imag   <= '0;
            for (int i = 0; i < DELAY; i++) begin
                ldl[i] <= '0;
                udl[i] <= '0;
            end
        end else begin
            out_valid <= in_valid && (pe || sel);
            out_sop   <= in_valid && !pe && kk == KD;
            if (in_valid) begin
                k                  <= kk + 1'b1;
                primed             <= pe || sel;
                {UO_real, UO_imag} <= udl[DELAY-1];
                {LO_real, LO_imag} <= y;
                ldl[0]             <= b;
                udl[0]             <= x;
                for (int i = 1; i < DELAY; i++) begin
                    ldl[i] <= ldl[i-1];
                    udl[i] <= udl[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_delay_commutator_mdc.sv
// tb_delay_commutator_mdc: random/directed check of DELAY=1,2,4,8 commutators against a frame-history model
module tb_delay_commutator_mdc;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_sop = 0;
    logic [11:0] UI_real = 0, UI_imag = 0, LI_real = 0, LI_imag = 0;
    logic        ov [4];
    logic        os [4];
    logic [11:0] uor [4], uoi [4], lor [4], loi [4];
    logic [23:0] ah [$];
    logic [23:0] bh [$];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : u
        delay_commutator_mdc #(.DATA_W(12), .DELAY(1 << g)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
            .UI_real(UI_real), .UI_imag(UI_imag), .LI_real(LI_real), .LI_imag(LI_imag),
            .out_valid(ov[g]), .out_sop(os[g]),
            .UO_real(uor[g]), .UO_imag(uoi[g]), .LO_real(lor[g]), .LO_imag(loi[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [23:0] a, input logic [23:0] b);
        int n, d;
        logic ev, es;
        logic [23:0] eu, el;
        in_valid = v;
        in_sop   = s;
        {UI_real, UI_imag} = a;
        {LI_real, LI_imag} = b;
        @(posedge clk);
        #1;
        n = -1;
        if (v) begin
            if (s) begin
                ah.delete();
                bh.delete();
            end
            ah.push_back(a);
            bh.push_back(b);
            n = ah.size() - 1;
        end
        for (int g = 0; g < 4; g++) begin
            d  = 1 << g;
            ev = v && n >= d;
            es = ev && n == d;
            check($sformatf("valid D%0d", d), 32'(ov[g]), 32'(ev));
            check($sformatf("sop D%0d", d), 32'(os[g]), 32'(es));
            if (ev) begin
                if ((n / d) % 2 == 1) begin
                    eu = ah[n-d];
                    el = ah[n];
                end else begin
                    eu = bh[n-2*d];
                    el = bh[n-d];
                end
                check($sformatf("UO D%0d n%0d", d, n), 32'({uor[g], uoi[g]}), 32'(eu));
                check($sformatf("LO D%0d n%0d", d, n), 32'({lor[g], loi[g]}), 32'(el));
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 0;
        for (int c = 0; c < cycles; c++) begin
            in_valid = 1;
            in_sop   = 0;
            {UI_real, UI_imag, LI_real, LI_imag} = 48'($urandom) ^ {$urandom, 16'h0};
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                check("rst valid", 32'(ov[g]), 0);
                check("rst sop", 32'(os[g]), 0);
                check("rst UO", 32'({uor[g], uoi[g]}), 0);
                check("rst LO", 32'({lor[g], loi[g]}), 0);
            end
        end
        ah.delete();
        bh.delete();
        rst_n = 1;
    endtask

    function automatic logic [23:0] cpx(input logic [11:0] r);
        return {r, 12'(-r)};
    endfunction

    initial begin
        do_reset(2);
        for (int k = 0; k < 40; k++)
            step(1, k == 0, cpx(12'(k)), cpx(12'(12'h100 + k)));
        step(1, 1, 24'($urandom), 24'($urandom));
        for (int k = 0; k < 64; k++)
            step(k % 2 == 1, 0, 24'($urandom), 24'($urandom));
        for (int k = 0; k < 5; k++)
            step(1, k == 0, 24'($urandom), 24'($urandom));
        for (int k = 0; k < 6; k++)
            step(1, k == 0, 24'($urandom), 24'($urandom));
        do_reset(1);
        for (int k = 0; k < 20; k++)
            step(1, 0, 24'($urandom), 24'($urandom));
        for (int k = 0; k < 40; k++)
            step(1, k == 0, k % 2 ? 24'h800_7FF : 24'h7FF_800, k % 3 ? 24'h7FF_800 : 24'h800_7FF);
        for (int k = 0; k < 600; k++)
            step($urandom % 4 != 0, $urandom % 50 == 0, 24'($urandom), 24'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
